// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared mode encoding for the pipelined barrel shifter.
// Modes 5..7 are illegal; they pass data through and flag an error.
package barrel_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_ROR = 3'd0,
    MODE_ROL = 3'd1,
    MODE_LSR = 3'd2,
    MODE_LSL = 3'd3,
    MODE_ASR = 3'd4
  } mode_e;

  function automatic logic is_legal_mode(
    input logic [MODE_W-1:0] m
  );
    return m <= MODE_ASR;
  endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Producer/consumer stream bundle for the barrel shifter.
// The slave side is the shifter, the master side drives operands.
interface barrel_shifter_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  import barrel_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_amount;
  logic [MODE_W-1:0]  in_mode;

  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_err;
  logic               out_zero;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_amount,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_err,
    output out_zero
  );

  modport master (
    output in_valid,
    output in_data,
    output in_amount,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_err,
    input  out_zero
  );

endinterface

// File: rtl/barrel_shifter_pipe_stage.sv
// One log2 step of the shifter: conditional shift by 2^STAGE,
// followed by the stage register that carries the beat onward.
module shift_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3,
  parameter int STAGE   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv_i,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] amount_i,
  input  logic [MODE_W-1:0]  mode_i,
  input  logic               sign_i,
  input  logic               err_i,
  output logic               valid_o,
  output logic [WIDTH-1:0]   data_o,
  output logic [SHAMT_W-1:0] amount_o,
  output logic [MODE_W-1:0]  mode_o,
  output logic               sign_o,
  output logic               err_o,
  output logic [WIDTH-1:0]   data_nxt_o
);

  localparam int DIST = 1 << STAGE;
  localparam int BACK = WIDTH - DIST;

  logic [WIDTH-1:0]   fill;
  logic [WIDTH-1:0]   data_d;
  logic               valid_q;
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] amount_q;
  logic [MODE_W-1:0]  mode_q;
  logic               sign_q;
  logic               err_q;

  // ASR fill uses the sign captured at input, not the current MSB
  assign fill = {WIDTH{sign_i}} << BACK;

  always_comb begin
    data_d = data_i;
    if (amount_i[STAGE] && !err_i) begin
      unique case (1'b1)
        mode_i == MODE_ROR:
          data_d = (data_i >> DIST) | (data_i << BACK);
        mode_i == MODE_ROL:
          data_d = (data_i << DIST) | (data_i >> BACK);
        mode_i == MODE_LSR:
          data_d = data_i >> DIST;
        mode_i == MODE_LSL:
          data_d = data_i << DIST;
        mode_i == MODE_ASR:
          data_d = (data_i >> DIST) | fill;
        default:
          data_d = data_i;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      amount_q <= '0;
      mode_q   <= '0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (adv_i) begin
      valid_q  <= valid_i;
      data_q   <= data_d;
      amount_q <= amount_i;
      mode_q   <= mode_i;
      sign_q   <= sign_i;
      err_q    <= err_i;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign amount_o   = amount_q;
  assign mode_o     = mode_q;
  assign sign_o     = sign_q;
  assign err_o      = err_q;
  assign data_nxt_o = data_d;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: SHAMT_W shift stages behind one
// global advance, so a stalled output freezes the whole pipe.
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  barrel_shifter_pipe_if.slave bus
);

  logic               adv;
  logic               valid_c [SHAMT_W+1];
  logic [WIDTH-1:0]   data_c  [SHAMT_W+1];
  logic [SHAMT_W-1:0] amt_c   [SHAMT_W+1];
  logic [MODE_W-1:0]  mode_c  [SHAMT_W+1];
  logic               sign_c  [SHAMT_W+1];
  logic               err_c   [SHAMT_W+1];
  logic [WIDTH-1:0]   last_nxt;
  logic               zero_d;
  logic               zero_q;
  logic               tail_unused;

  assign adv = bus.out_ready | ~valid_c[SHAMT_W];
  assign bus.in_ready = adv;

  assign valid_c[0] = bus.in_valid;
  assign data_c[0]  = bus.in_data;
  assign amt_c[0]   = bus.in_amount;
  assign mode_c[0]  = bus.in_mode;
  assign sign_c[0]  = bus.in_data[WIDTH-1];
  assign err_c[0]   = ~is_legal_mode(bus.in_mode);

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    logic [WIDTH-1:0] nxt;

    shift_stage #(
      .WIDTH  (WIDTH),
      .SHAMT_W(SHAMT_W),
      .STAGE  (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv_i     (adv),
      .valid_i   (valid_c[k]),
      .data_i    (data_c[k]),
      .amount_i  (amt_c[k]),
      .mode_i    (mode_c[k]),
      .sign_i    (sign_c[k]),
      .err_i     (err_c[k]),
      .valid_o   (valid_c[k+1]),
      .data_o    (data_c[k+1]),
      .amount_o  (amt_c[k+1]),
      .mode_o    (mode_c[k+1]),
      .sign_o    (sign_c[k+1]),
      .err_o     (err_c[k+1]),
      .data_nxt_o(nxt)
    );

    if (k == SHAMT_W-1) begin : g_last
      assign last_nxt = nxt;
    end else begin : g_mid
      logic [WIDTH-1:0] nxt_unused;
      assign nxt_unused = nxt;
    end
  end

  assign tail_unused = ^{amt_c[SHAMT_W],
                         mode_c[SHAMT_W],
                         sign_c[SHAMT_W]};

  // zero flag is formed from the final mux and loaded with the data
  assign zero_d = valid_c[SHAMT_W-1] & ~|last_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (adv) begin
      zero_q <= zero_d;
    end
  end

  assign bus.out_valid = valid_c[SHAMT_W];
  assign bus.out_data  = data_c[SHAMT_W];
  assign bus.out_err   = err_c[SHAMT_W];
  assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe (WIDTH=8).
// Expected beats are queued at drive time and popped on output.
module tb_barrel_shifter_pipe;
  import barrel_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  barrel_shifter_pipe_if #(.WIDTH(W)) bus ();

  barrel_shifter_pipe #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         err;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got data=%h err=%b required=none",
                 bus.out_data, bus.out_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.out_data, bus.out_err, bus.out_zero}
            !== {e.d, e.err, e.zero}) begin
          errors++;
          $display("FAIL beat got d=%h e=%b z=%b required d=%h e=%b z=%b",
                   bus.out_data, bus.out_err, bus.out_zero,
                   e.d, e.err, e.zero);
        end
      end
    end
  end

  function automatic logic [W-1:0] model(
    input logic [W-1:0] d, input int a, input int m
  );
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < W; i++) begin
      case (m)
        0: r[i] = d[(i + a) % W];
        1: r[i] = d[(i - a + W) % W];
        2: r[i] = (i + a < W) ? d[i + a] : 1'b0;
        3: r[i] = (i >= a) ? d[i - a] : 1'b0;
        4: r[i] = (i + a < W) ? d[i + a] : d[W-1];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic send(
    input logic [W-1:0] d, input logic [2:0] a,
    input logic [2:0] m, input logic [W-1:0] ed,
    input logic ee, input bit track
  );
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amount = a;
    bus.in_mode   = m;
    if (track) sb.push_back('{d: ed, err: ee, zero: (ed == '0)});
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amount = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got=%b required=0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_out_data got=%h required=00", bus.out_data);
    end
    checks++;
    if (bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_err got=%b required=0", bus.out_err);
    end
    checks++;
    if (bus.out_zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_zero got=%b required=0", bus.out_zero);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready got=%b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    send(8'h81, 3'd1, MODE_ROR, 8'hC0, 1'b0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_edge0 out_valid=%b required=0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_edge1 out_valid=%b required=0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC0) begin
      errors++;
      $display("FAIL lat_edge2 valid=%b data=%h required 1/c0",
               bus.out_valid, bus.out_data);
    end
    drain();
  endtask

  task automatic test_modes();
    send(8'h80, 3'd3, MODE_ASR, 8'hF0, 1'b0, 1'b1);
    send(8'h80, 3'd3, MODE_LSR, 8'h10, 1'b0, 1'b1);
    send(8'h81, 3'd7, MODE_LSL, 8'h80, 1'b0, 1'b1);
    send(8'h81, 3'd4, MODE_ROL, 8'h18, 1'b0, 1'b1);
    send(8'h01, 3'd1, MODE_LSL, 8'h02, 1'b0, 1'b1);
    send(8'h01, 3'd1, MODE_LSR, 8'h00, 1'b0, 1'b1);
    send(8'h81, 3'd7, MODE_ROR, 8'h03, 1'b0, 1'b1);
    send(8'hC3, 3'd7, MODE_ASR, 8'hFF, 1'b0, 1'b1);
    for (int m = 0; m < 5; m++) begin
      send(8'hA5, 3'd0, 3'(m), 8'hA5, 1'b0, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] d;
      int a;
      int m;
      d = 8'($urandom);
      a = $urandom_range(0, 7);
      m = $urandom_range(0, 4);
      send(d, 3'(a), 3'(m), model(d, a, m), 1'b0, 1'b1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [W-1:0] d;
          d = 8'(8'h13 * (i + 1));
          send(d, 3'(i + 1), MODE_ROL, model(d, i + 1, 1), 1'b0, 1'b1);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        held = bus.out_data;
        checks++;
        if (bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_valid got=%b required=1", bus.out_valid);
        end
        repeat (4) begin
          @(negedge clk);
          checks++;
          if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready got=%b required=0", bus.in_ready);
          end
          checks++;
          if (bus.out_data !== held) begin
            errors++;
            $display("FAIL bp_hold got=%h required=%h", bus.out_data, held);
          end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_illegal();
    send(8'h5A, 3'd5, 3'd6, 8'h5A, 1'b1, 1'b1);
    send(8'h5A, 3'd5, MODE_LSR, 8'h02, 1'b0, 1'b1);
    send(8'h00, 3'd3, 3'd7, 8'h00, 1'b1, 1'b1);
    send(8'h3C, 3'd2, MODE_ROR, 8'h0F, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_random_ready();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [W-1:0] d;
          int a;
          int m;
          d = 8'($urandom);
          a = $urandom_range(0, 7);
          m = $urandom_range(0, 7);
          send(d, 3'(a), 3'(m), model(d, a, m), 1'(m > 4), 1'b1);
        end
      end
      begin
        for (int c = 0; c < 50; c++) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    send(8'h33, 3'd1, MODE_ROR, 8'h00, 1'b0, 1'b0);
    send(8'h44, 3'd2, MODE_LSL, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_valid got=%b required=0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_ready got=%b required=1", bus.in_ready);
    end
    #4;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_ghost got=%b required=0", bus.out_valid);
    end
    send(8'h0F, 3'd4, MODE_ROL, 8'hF0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_early got=%b required=0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hF0) begin
      errors++;
      $display("FAIL mid_rst_fresh valid=%b data=%h required 1/f0",
               bus.out_valid, bus.out_data);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_backpressure();
    test_illegal();
    test_random_ready();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired required=finish");
    $fatal(1);
  end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined successor to the combinational 8-bit rotate-right barrel shifter.
- Generalises width and adds four shift modes: rotate right, rotate left, logical shift left/right and arithmetic shift right.
- Registers one log2 stage per cycle behind a valid/ready handshake with full backpressure.
- Sits between a producer and a consumer stream in datapath labs, for example an ALU shift unit.

Parameters:
- WIDTH, 8: data width in bits. Must be a power of two, at least 2.
- SHAMT_W, $clog2(WIDTH): shift-amount width and number of pipeline stages. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat this cycle.
- in_data  input  WIDTH  operand.
- in_amount  input  SHAMT_W  shift distance, 0..WIDTH-1.
- in_mode  input  3  0=ROR, 1=ROL, 2=LSR, 3=LSL, 4=ASR; 5..7 are illegal.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- out_err  output  1  the beat carried an illegal mode.
- out_zero  output  1  out_data is all zeros; qualified by out_valid.

Behaviour:
- Reset state: asserting rst_n low asynchronously clears every stage valid bit, out_valid, out_data, out_err and out_zero to 0. in_ready is combinational and is therefore 1 out of reset.
- Handshake:
  - A transfer occurs when valid and ready are both 1 on a rising edge.
  - Once out_valid is high, out_data, out_err and out_zero hold stable until accepted.
- Pipeline advance:
  - A global advance = out_ready | ~out_valid.
  - in_ready = advance.
  - On advance, every stage register loads from its predecessor, valid bit included.
  - With no advance, all stages hold.
  - Bubbles are not compressed.
- Latency: exactly SHAMT_W cycles from an accepted input to out_valid, when not stalled (3 for WIDTH=8). Throughput is 1 beat per cycle with out_ready held high.
- Stage k (k = 0..SHAMT_W-1):
  - If amount bit k is set, the stage shifts its data by 2^k in the requested direction. Otherwise data passes unchanged.
  - Amount, mode and err travel with the data through every stage.
- Per-mode fill:
  - ROR/ROL: vacated bits come from the wrapped bits.
  - LSR/LSL: vacated bits are 0.
  - ASR: vacated MSBs copy the original sign bit. The sign bit is captured at input and carried through the stages.
- Illegal mode (5..7): data passes through unshifted whatever the amount, and out_err=1 for that beat.
- out_zero: computed in the last stage from the shifted data; registered alongside it.
- Boundary conditions:
  - amount=0 gives data unchanged in every mode.
  - amount=WIDTH-1 is the maximum; there is no modulo beyond the port width.
- Simultaneous events: an input accept and an output accept in the same cycle are both taken; there is no lost or duplicated beat.
- Reset mid-operation: all in-flight beats are discarded. The first output after reset is the first beat accepted after reset.
- Input beats with in_valid=0 enter the pipeline as bubbles. Their data is don't-care.

Decomposition:
- Shared package barrel_pkg holds:
  - mode constants MODE_ROR, MODE_ROL, MODE_LSR, MODE_LSL, MODE_ASR;
  - MODE_W=3;
  - a function is_legal_mode.
- Sub-module shift_stage, parameterised by WIDTH and STAGE (shift distance 2^STAGE), is instantiated SHAMT_W times in a generate loop. Each instance contains:
  - one combinational mux stage;
  - the stage register for valid, data, amount, mode, sign and err, with enable = advance.
- The top level holds only the advance logic, zero detect and the output mapping.

Test Plan:
- WIDTH=8, in 0x81, ROR, amount 1 -> out 0xC0 exactly 3 cycles later, err=0, zero=0.
- ASR of 0x80 by 3 -> 0xF0. LSR of 0x80 by 3 -> 0x10. LSL of 0x81 by 7 -> 0x80. ROL of 0x81 by 4 -> 0x18.
- LSL of 0x01 by 1 -> 0x02 with zero=0. LSR of 0x01 by 1 -> 0x00 with zero=1.
- Backpressure:
  - Stream 6 back-to-back beats and drop out_ready low for 4 cycles mid-stream.
  - Required: in_ready low while stalled, out_data stable, all 6 results in order, none lost or duplicated.
- Illegal mode 6, data 0x5A, amount 5 -> out 0x5A with out_err=1. The next legal beat has out_err=0.
- Accept 2 beats, then pulse rst_n low for half a cycle -> out_valid=0 immediately and neither beat ever appears. in_ready=1 after reset; a fresh beat returns after 3 cycles.
